// File: rtl/uart_gpio_responder_if.sv
// Serial link and GPIO pins of the UART GPIO responder.
// master = host/bench side, slave = responder.
interface uart_gpio_responder_if;
  logic       io_rxd;
  logic       io_txd;
  logic [7:0] io_sw;
  logic [7:0] io_led;
  logic       io_busy;
  logic       io_frameError;
  logic       io_overrun;

  modport master (
    output io_rxd, io_sw,
    input  io_txd, io_led, io_busy, io_frameError, io_overrun
  );

  modport slave (
    input  io_rxd, io_sw,
    output io_txd, io_led, io_busy, io_frameError, io_overrun
  );
endinterface

// File: rtl/uart_gpio_responder.sv
// Purpose: 8N1 UART responder executing 'W'<data> (LED write) and 'R' (switch read) commands.
// Latency: reply start bit drives io_txd low 2 cycles after the stop-bit sample of the triggering byte.
// Backpressure: none; a byte arriving while a reply is in flight is dropped and flagged on io_overrun.
module uart_gpio_responder #(
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMEOUT_CLKS = 1000000
) (
  input  logic                  io_mainClk,
  input  logic                  io_resetn,
  uart_gpio_responder_if.slave  bus
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0] WAIT_LAST = 32'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {IDLE, WDATA, RESP} cmd_state_t;

  logic        rxd_meta, rxd_sync, rxd_prev;
  logic [1:0]  prime;
  logic        armed;
  rx_state_t   rx_state, rx_nxt;
  logic        rx_tick;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh;
  logic        rx_valid;
  logic        frame_err;

  cmd_state_t  state, nxt;
  logic [31:0] wd_cnt;
  logic [7:0]  led;
  logic        led_we;
  logic        overrun, ovr;

  logic        tx_load;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [9:0]  tx_sh;
  logic [15:0] tx_cnt;
  logic [3:0]  tx_bit;
  logic        txd;

  // Receiver sequencing: start re-check at mid-bit, then one sample per bit period.
  always_comb begin
    rx_nxt  = rx_state;
    rx_tick = 1'b0;
    case (rx_state)
      RX_IDLE:  if (armed && rxd_prev && !rxd_sync) rx_nxt = RX_START;
      RX_START: if (rx_cnt == HALF_LAST) begin
                  rx_tick = 1'b1;
                  rx_nxt  = rxd_sync ? RX_IDLE : RX_DATA;
                end
      RX_DATA:  if (rx_cnt == BIT_LAST) begin
                  rx_tick = 1'b1;
                  if (rx_bit == 3'd7) rx_nxt = RX_STOP;
                end
      RX_STOP:  if (rx_cnt == BIT_LAST) begin
                  rx_tick = 1'b1;
                  rx_nxt  = RX_IDLE;
                end
      default:  rx_nxt = RX_IDLE;
    endcase
  end

  // prime marks when rxd_sync carries a post-reset line sample, so a line held
  // low through reset never arms the start detector.
  always_ff @(posedge io_mainClk) begin
    if (!io_resetn) begin
      rxd_meta  <= 1'b1;
      rxd_sync  <= 1'b1;
      rxd_prev  <= 1'b1;
      prime     <= 2'b00;
      armed     <= 1'b0;
      rx_state  <= RX_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_sh     <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rxd_meta  <= bus.io_rxd;
      rxd_sync  <= rxd_meta;
      rxd_prev  <= rxd_sync;
      prime     <= {prime[0], 1'b1};
      armed     <= armed | (prime[1] & rxd_sync);
      rx_state  <= rx_nxt;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (rx_tick || rx_state == RX_IDLE) rx_cnt <= '0;
      else                                rx_cnt <= rx_cnt + 16'd1;
      if (rx_state == RX_IDLE) rx_bit <= '0;
      if (rx_tick && rx_state == RX_DATA) begin
        rx_sh  <= {rxd_sync, rx_sh[7:1]};
        rx_bit <= rx_bit + 3'd1;
      end
      if (rx_tick && rx_state == RX_STOP) begin
        rx_valid  <= rxd_sync;
        frame_err <= !rxd_sync;
      end
    end
  end

  always_comb begin
    nxt     = state;
    tx_load = 1'b0;
    tx_data = 8'h00;
    led_we  = 1'b0;
    ovr     = 1'b0;
    if (frame_err) begin
      nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (rx_valid) begin
                if (rx_sh == 8'h57) begin
                  nxt = WDATA;
                end else begin
                  tx_load = 1'b1;
                  tx_data = (rx_sh == 8'h52) ? bus.io_sw : 8'h3F;
                  nxt     = RESP;
                end
              end
        WDATA: if (rx_valid) begin
                 led_we  = 1'b1;
                 tx_load = 1'b1;
                 tx_data = 8'h4B;
                 nxt     = RESP;
               end else if (wd_cnt == WAIT_LAST) begin
                 nxt = IDLE;
               end
        RESP: begin
                ovr = rx_valid;
                if (!tx_busy) nxt = IDLE;
              end
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge io_mainClk) begin
    if (!io_resetn) begin
      state   <= IDLE;
      wd_cnt  <= '0;
      led     <= '0;
      overrun <= 1'b0;
    end else begin
      state   <= nxt;
      wd_cnt  <= (state == WDATA) ? wd_cnt + 32'd1 : 32'd0;
      overrun <= ovr;
      if (led_we) led <= rx_sh;
    end
  end

  // A load while a frame is still shifting out is ignored so the line is never corrupted.
  always_ff @(posedge io_mainClk) begin
    if (!io_resetn) begin
      tx_busy <= 1'b0;
      tx_sh   <= '1;
      tx_cnt  <= '0;
      tx_bit  <= '0;
      txd     <= 1'b1;
    end else if (!tx_busy) begin
      if (tx_load) begin
        tx_busy <= 1'b1;
        tx_sh   <= {1'b1, tx_data, 1'b0};
        txd     <= 1'b0;
        tx_cnt  <= '0;
        tx_bit  <= '0;
      end
    end else if (tx_cnt == BIT_LAST) begin
      tx_cnt <= '0;
      if (tx_bit == 4'd9) begin
        tx_busy <= 1'b0;
        txd     <= 1'b1;
      end else begin
        tx_bit <= tx_bit + 4'd1;
        tx_sh  <= {1'b1, tx_sh[9:1]};
        txd    <= tx_sh[1];
      end
    end else begin
      tx_cnt <= tx_cnt + 16'd1;
    end
  end

  assign bus.io_txd        = txd;
  assign bus.io_led        = led;
  assign bus.io_busy       = (state != IDLE);
  assign bus.io_frameError = frame_err;
  assign bus.io_overrun    = overrun;

endmodule

// File: tb/tb_uart_gpio_responder.sv
// Directed bench for uart_gpio_responder: drives 8N1 frames, decodes replies against a queue of expected bytes and start cycles.
module tb_uart_gpio_responder;
  localparam int CPB = 16;
  localparam int TMO = 1000;
  localparam int LAT = 156;  // negedge of first start-bit low on rxd to negedge showing reply start bit

  typedef struct {
    logic [7:0] b;
    int         t;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   fe_cnt = 0;
  int   ov_cnt = 0;
  int   frames = 0;
  logic mon_active = 1'b0;
  exp_t exp_q[$];

  uart_gpio_responder_if bus();

  uart_gpio_responder #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
    .io_mainClk(clk),
    .io_resetn (resetn),
    .bus       (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.io_frameError === 1'b1) fe_cnt++;
    if (bus.io_overrun === 1'b1) ov_cnt++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stopb, output int c);
    @(negedge clk);
    c = cyc;
    bus.io_rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.io_rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    bus.io_rxd = stopb;
    repeat (CPB) @(negedge clk);
    bus.io_rxd = 1'b1;
  endtask

  task automatic expect_reply(input logic [7:0] b, input int c);
    exp_t e;
    e.b = b;
    e.t = c + LAT;
    exp_q.push_back(e);
  endtask

  task automatic wait_quiet(input string tag);
    int done;
    done = 0;
    for (int i = 0; i < 3000 && done == 0; i++) begin
      @(negedge clk);
      if (!mon_active && exp_q.size() == 0 && bus.io_busy === 1'b0) done = 1;
    end
    chk(tag, done, 1);
  endtask

  // Reply decoder: samples each bit at its centre; frames cut by reset are discarded.
  initial begin
    logic       prev_txd, sbit, stopb, ab;
    logic [7:0] d;
    int         t0;
    exp_t       e;
    prev_txd = 1'b1;
    forever begin
      @(negedge clk);
      if (resetn && prev_txd === 1'b1 && bus.io_txd === 1'b0) begin
        mon_active = 1'b1;
        t0 = cyc;
        ab = 1'b0;
        sbit = 1'b1;
        stopb = 1'b0;
        d = 8'h00;
        for (int j = 1; j <= 152; j++) begin
          @(negedge clk);
          if (!resetn) ab = 1'b1;
          if (j == 8) sbit = bus.io_txd;
          if (j >= 24 && j <= 136 && (j - 8) % 16 == 0) d[(j - 24) / 16] = bus.io_txd;
          if (j == 152) stopb = bus.io_txd;
        end
        if (!ab) begin
          frames++;
          chk("reply_expected", int'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("reply_byte", int'(d), int'(e.b));
            chk("reply_start_cycle", t0, e.t);
            chk("reply_start_bit", int'(sbit), 0);
            chk("reply_stop_bit", int'(stopb), 1);
          end
        end
        mon_active = 1'b0;
      end
      prev_txd = bus.io_txd;
    end
  end

  initial begin
    int c, c2, fe0, ov0, f0;
    bus.io_rxd = 1'b1;
    bus.io_sw  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_txd", int'(bus.io_txd), 1);
    chk("rst_led", int'(bus.io_led), 0);
    chk("rst_busy", int'(bus.io_busy), 0);
    chk("rst_frame_error", int'(bus.io_frameError), 0);
    chk("rst_overrun", int'(bus.io_overrun), 0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);

    // write command, reply timing and busy release
    send_frame(8'h57, 1'b1, c);
    chk("w_busy_wdata", int'(bus.io_busy), 1);
    send_frame(8'hA5, 1'b1, c2);
    expect_reply(8'h4B, c2);
    repeat (LAT) @(negedge clk);
    chk("w_led", int'(bus.io_led), 8'hA5);
    chk("w_busy_last_stop", int'(bus.io_busy), 1);
    @(negedge clk);
    chk("w_busy_fall", int'(bus.io_busy), 0);
    wait_quiet("w_quiet");

    // read command; switches changed mid-reply must not leak into the frame
    bus.io_sw = 8'h3C;
    send_frame(8'h52, 1'b1, c);
    expect_reply(8'h3C, c);
    repeat (40) @(negedge clk);
    bus.io_sw = 8'hFF;
    wait_quiet("r_quiet");

    send_frame(8'h00, 1'b1, c);
    expect_reply(8'h3F, c);
    wait_quiet("unk_quiet");

    // write timeout: busy holds exactly TMO cycles after entering WDATA
    send_frame(8'h57, 1'b1, c);
    repeat (LAT - 160 + TMO - 2) @(negedge clk);
    chk("tmo_busy_before", int'(bus.io_busy), 1);
    repeat (3) @(negedge clk);
    chk("tmo_busy_after", int'(bus.io_busy), 0);
    chk("tmo_led_kept", int'(bus.io_led), 8'hA5);
    repeat (200) @(negedge clk);

    // bad stop bit: one pulse, FSM stays idle so the next byte is a plain command
    fe0 = fe_cnt;
    send_frame(8'h57, 1'b0, c);
    repeat (5) @(negedge clk);
    chk("fe_pulse", fe_cnt - fe0, 1);
    chk("fe_busy", int'(bus.io_busy), 0);
    send_frame(8'hA5, 1'b1, c);
    expect_reply(8'h3F, c);
    wait_quiet("fe_quiet");
    chk("fe_led_kept", int'(bus.io_led), 8'hA5);

    // short glitch is a false start
    fe0 = fe_cnt;
    @(negedge clk);
    bus.io_rxd = 1'b0;
    repeat (4) @(negedge clk);
    bus.io_rxd = 1'b1;
    repeat (200) @(negedge clk);
    chk("glitch_fe", fe_cnt - fe0, 0);
    chk("glitch_busy", int'(bus.io_busy), 0);

    // second command during the reply is dropped
    ov0 = ov_cnt;
    f0 = frames;
    bus.io_sw = 8'h5A;
    send_frame(8'h52, 1'b1, c);
    expect_reply(8'h5A, c);
    send_frame(8'h52, 1'b1, c2);
    wait_quiet("ovr_quiet");
    repeat (200) @(negedge clk);
    chk("ovr_pulse", ov_cnt - ov0, 1);
    chk("ovr_one_reply", frames - f0, 1);

    // reset in the middle of a reply
    send_frame(8'h52, 1'b1, c);
    repeat (40) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk("mid_rst_txd", int'(bus.io_txd), 1);
    chk("mid_rst_led", int'(bus.io_led), 0);
    chk("mid_rst_busy", int'(bus.io_busy), 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (200) @(negedge clk);
    send_frame(8'h57, 1'b1, c);
    send_frame(8'h66, 1'b1, c2);
    expect_reply(8'h4B, c2);
    wait_quiet("post_rst_quiet");
    chk("post_rst_led", int'(bus.io_led), 8'h66);

    // line held low across reset release must not look like a start bit
    fe0 = fe_cnt;
    f0 = frames;
    resetn = 1'b0;
    bus.io_rxd = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (50) @(negedge clk);
    bus.io_rxd = 1'b1;
    repeat (300) @(negedge clk);
    chk("low_rel_busy", int'(bus.io_busy), 0);
    chk("low_rel_fe", fe_cnt - fe0, 0);
    chk("low_rel_frames", frames - f0, 0);
    bus.io_sw = 8'hC3;
    send_frame(8'h52, 1'b1, c);
    expect_reply(8'hC3, c);
    wait_quiet("low_rel_quiet");

    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
